// File: rtl/local_inject_arbiter.sv
// local_inject_arbiter
//   Purpose : round-robin share of one router Local input port among NUM_REQ
//             processing-element injectors. The winner's packet is latched and
//             the router grant is returned to the winner as a one-cycle pulse.
//             A timeout abandons a request that the router never grants.
//   Latency : request seen in IDLE -> ReqDnStr/PacketOut on the next edge;
//             GntDnStr -> GntUpStr on the next edge; 3 cycles minimum per packet.
//   Backpressure : DnStrFull blocks arbitration in IDLE only. UpStrFull is a
//             combinational copy of DnStrFull.
//   Ports   : clk, reset (sync, active-high)
//             ReqUpStr/PacketIn/GntUpStr/UpStrFull : injector side
//             ReqDnStr/PacketOut/GntDnStr/DnStrFull : router Local side
//             Owner, TimeoutErr, PktCount           : status
module local_inject_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int packetwidth = 56,
  parameter int TIMEOUT     = 1023
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             ReqUpStr,
  input  logic [NUM_REQ*packetwidth-1:0] PacketIn,
  output logic [NUM_REQ-1:0]             GntUpStr,
  output logic                           UpStrFull,
  output logic                           ReqDnStr,
  output logic [packetwidth-1:0]         PacketOut,
  input  logic                           GntDnStr,
  input  logic                           DnStrFull,
  output logic [2:0]                     Owner,
  output logic                           TimeoutErr,
  output logic [15:0]                    PktCount
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_GNT, S_RELEASE} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t                   r_state, w_state_nxt;
  logic [2:0]               r_ptr, w_ptr_nxt;
  logic [15:0]              r_timer, w_timer_nxt;
  logic                     r_req_dn, w_req_dn_nxt;
  logic [NUM_REQ-1:0]       r_gnt_up, w_gnt_up_nxt;
  logic [packetwidth-1:0]   r_pkt_out, w_pkt_out_nxt;
  logic [2:0]               r_owner, w_owner_nxt;
  logic                     r_timeout_err, w_timeout_err_nxt;
  logic [15:0]              r_pkt_count, w_pkt_count_nxt;

  // Request and packet views padded to 8 entries so a 3-bit index always fits.
  logic [7:0]               w_req_ext;
  logic [packetwidth-1:0]   w_pkt_arr [8];
  logic [2:0]               w_winner;
  logic [2:0]               w_ptr_adv;
  logic                     w_to_hit;

  assign w_req_ext = 8'(ReqUpStr);

  for (genvar g = 0; g < 8; g++) begin : g_pkt
    if (g < NUM_REQ) begin : g_real
      assign w_pkt_arr[g] = PacketIn[g*packetwidth +: packetwidth];
    end else begin : g_pad
      assign w_pkt_arr[g] = '0;
    end
  end

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    w_winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      logic [3:0] w_sum;
      w_sum = {1'b0, r_ptr} + 4'(i);
      if (w_sum >= 4'(NUM_REQ)) w_sum = w_sum - 4'(NUM_REQ);
      if (w_req_ext[w_sum[2:0]]) w_winner = w_sum[2:0];
    end
  end

  // Pointer moves past the owner whether it was granted or timed out.
  assign w_ptr_adv = (r_owner == 3'(NUM_REQ - 1)) ? 3'd0 : r_owner + 3'd1;
  assign w_to_hit  = (TIMEOUT != 0) && (r_timer == TO_LAST);

  always_comb begin
    w_state_nxt       = r_state;
    w_ptr_nxt         = r_ptr;
    w_timer_nxt       = r_timer;
    w_req_dn_nxt      = r_req_dn;
    w_gnt_up_nxt      = r_gnt_up;
    w_pkt_out_nxt     = r_pkt_out;
    w_owner_nxt       = r_owner;
    w_timeout_err_nxt = r_timeout_err;
    w_pkt_count_nxt   = r_pkt_count;
    case (r_state)
      S_IDLE: begin
        if (!DnStrFull && (|ReqUpStr)) begin
          w_pkt_out_nxt = w_pkt_arr[w_winner];
          w_owner_nxt   = w_winner;
          w_req_dn_nxt  = 1'b1;
          w_timer_nxt   = '0;
          w_state_nxt   = S_WAIT_GNT;
        end
      end
      S_WAIT_GNT: begin
        // A grant on the timeout edge takes priority over the timeout.
        if (GntDnStr) begin
          w_req_dn_nxt    = 1'b0;
          w_gnt_up_nxt    = NUM_REQ'(8'b1 << r_owner);
          w_pkt_count_nxt = r_pkt_count + 16'd1;
          w_ptr_nxt       = w_ptr_adv;
          w_state_nxt     = S_RELEASE;
        end else if (w_to_hit) begin
          w_req_dn_nxt      = 1'b0;
          w_timeout_err_nxt = 1'b1;
          w_ptr_nxt         = w_ptr_adv;
          w_state_nxt       = S_RELEASE;
        end else begin
          w_timer_nxt = r_timer + 16'd1;
        end
      end
      S_RELEASE: begin
        // One idle cycle lets the granted injector drop its request.
        w_gnt_up_nxt      = '0;
        w_timeout_err_nxt = 1'b0;
        w_state_nxt       = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_timer       <= '0;
      r_req_dn      <= 1'b0;
      r_gnt_up      <= '0;
      r_pkt_out     <= '0;
      r_owner       <= '0;
      r_timeout_err <= 1'b0;
      r_pkt_count   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_ptr         <= w_ptr_nxt;
      r_timer       <= w_timer_nxt;
      r_req_dn      <= w_req_dn_nxt;
      r_gnt_up      <= w_gnt_up_nxt;
      r_pkt_out     <= w_pkt_out_nxt;
      r_owner       <= w_owner_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_pkt_count   <= w_pkt_count_nxt;
    end
  end

  assign UpStrFull  = DnStrFull;
  assign ReqDnStr   = r_req_dn;
  assign GntUpStr   = r_gnt_up;
  assign PacketOut  = r_pkt_out;
  assign Owner      = r_owner;
  assign TimeoutErr = r_timeout_err;
  assign PktCount   = r_pkt_count;

endmodule

// File: doc/local_inject_arbiter.md
# local_inject_arbiter

Round-robin arbiter that lets up to NUM_REQ processing-element injectors share one router Local input port. It sits between the injectors' ReqDnStr/GntDnStr/DnStrFull/PacketOut handshake and the router's Local port, and presents the same handshake on both sides. It latches the winning packet and forwards the router grant back to the winner. A timeout guards against a stalled downstream port.

## Interface
- NUM_REQ, 4: number of injectors; legal range 2..8.
- packetwidth, 56: packet bus width.
- TIMEOUT, 1023: maximum cycles spent in WAIT_GNT. 0 disables the timeout.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- ReqUpStr  in  NUM_REQ  per-injector request; bit i belongs to injector i.
- PacketIn  in  NUM_REQ*packetwidth  injector i packet on bits [i*packetwidth +: packetwidth].
- GntUpStr  out  NUM_REQ  one-hot, one-cycle grant to the winning injector.
- UpStrFull  out  1  broadcast full flag to the injectors; combinational copy of DnStrFull.
- ReqDnStr  out  1  request to the router Local port.
- PacketOut  out  packetwidth  latched winning packet.
- GntDnStr  in  1  grant from the router Local port.
- DnStrFull  in  1  router Local FIFO full.
- Owner  out  3  index of the current or most recent winner.
- TimeoutErr  out  1  one-cycle pulse when a request is abandoned.
- PktCount  out  16  count of packets successfully handed off; wraps.

## Operation
- The block has three states: IDLE, WAIT_GNT and RELEASE. A 3-bit round-robin pointer `ptr` gives the highest-priority index. A 16-bit WAIT_GNT timer counts time in WAIT_GNT.
- **IDLE**, when DnStrFull=0 and any ReqUpStr bit is set:
  - Winner = first set bit scanning ptr, ptr+1, …, NUM_REQ-1, 0, ….
  - On the same edge: PacketOut ← PacketIn[winner], Owner ← winner, ReqDnStr ← 1, timer ← 0, go to WAIT_GNT.
  - Otherwise stay in IDLE.
- **WAIT_GNT**:
  - If GntDnStr=1: ReqDnStr ← 0, GntUpStr[Owner] ← 1, PktCount ← PktCount+1, ptr ← (Owner==NUM_REQ-1) ? 0 : Owner+1, go to RELEASE.
  - Else, if TIMEOUT≠0 and timer==TIMEOUT-1: ReqDnStr ← 0, TimeoutErr ← 1, advance ptr exactly as above, go to RELEASE. No grant is issued, so the injector keeps requesting and is retried later.
  - Else timer ← timer+1.
- **RELEASE**: GntUpStr ← 0, TimeoutErr ← 0, go to IDLE. This one-cycle gap lets the granted injector drop its request before the next arbitration.
- PacketOut and Owner hold their values until the next arbitration.
- GntUpStr is never asserted for more than one bit or more than one cycle.

## Timing
- Reset values: ReqDnStr=0, GntUpStr=0, PacketOut=0, Owner=0, TimeoutErr=0, PktCount=0. Internal reset values: ptr=0, timer=0, state IDLE.
- Reset asserted in any state forces these values on that edge. Any in-flight request is dropped without a grant and without a TimeoutErr pulse.
- Request latency: ReqUpStr sampled at edge k with the block in IDLE gives ReqDnStr=1 and a valid PacketOut after edge k.
- Grant latency: GntDnStr sampled at edge m gives GntUpStr high for the cycle after edge m.
- Minimum period per packet is 3 cycles (IDLE, WAIT_GNT, RELEASE), reached with an immediate router grant.
- Simultaneous events and boundary conditions:
  - GntDnStr=1 and timeout on the same edge: the grant wins and TimeoutErr stays 0.
  - DnStrFull rising during WAIT_GNT is ignored, because the request is already issued.
  - An injector dropping ReqUpStr during WAIT_GNT does not abort the transfer; the data is already latched.
  - DnStrFull=1 in IDLE blocks arbitration regardless of requests.
  - PktCount wraps 65535 → 0.
  - ptr wraps NUM_REQ-1 → 0.
  - ReqUpStr bits at index ≥ NUM_REQ do not exist; the Owner upper bits are 0 when NUM_REQ ≤ 4.

## Test plan
- Single request, immediate grant: ReqUpStr=0001, PacketIn[0]=56'hA5, GntDnStr high the cycle after ReqDnStr. Required: ReqDnStr high 1 cycle, PacketOut=56'hA5, GntUpStr=0001 for 1 cycle, Owner=0, PktCount=1.
- Fairness: ReqUpStr=1111 held continuously, router grants every request immediately. Required: winners 0,1,2,3,0,…, GntUpStr pulses spaced 3 cycles apart, PktCount=8 after 8 grants.
- Full back-pressure: DnStrFull=1 with ReqUpStr=0100 for 20 cycles. Required: ReqDnStr stays 0 and UpStrFull=1. Then release DnStrFull: ReqDnStr rises on the next edge, Owner=2.
- Timeout: TIMEOUT=8, ReqUpStr=0010, GntDnStr held 0. Required: ReqDnStr high for exactly 8 cycles, TimeoutErr pulses once, GntUpStr never set, PktCount unchanged. Injector 1 is re-arbitrated 2 cycles later.
- Grant/timeout collision: TIMEOUT=4, GntDnStr asserted on the 4th WAIT_GNT cycle. Required: GntUpStr pulses, TimeoutErr=0, PktCount increments.
- Mid-transfer reset and wrap: reset asserted during WAIT_GNT gives all outputs 0 on the next edge. Separately, preload 65535 grants (or force PktCount); the next grant gives PktCount=0.
